temp_meas_ctrl: RTL and testbench

Measurement sequencer for the temperature-dependent delay sensor (`tempsense`, wrapped as `temp_sensor`). On request it does four things in order:
- loads the DAC code and enables the DAC;
- precharges the sensor node for a programmable number of cycles;
- releases precharge and counts clock cycles until the sensor output rises;
- reports the count with a done pulse.

The count is a digital temperature code. A timeout guards against a sensor that never fires. This block sits between the chip-level register/IO logic and the analog delay cell.

---
 rtl/temp_meas_if.sv | 29 ++
 rtl/temp_meas_ctrl.sv | 146 ++++++++++++++
 tb/tb_temp_meas_ctrl.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/temp_meas_if.sv
// Request/result and sensor-drive signals of the temperature measurement sequencer.
// The slave modport is the sequencer side; master is the register/IO and sensor side.
interface temp_meas_if #(
    parameter int N_VDAC = 6,
    parameter int N_CNT  = 12,
    parameter int N_PRE  = 4
);
    logic              i_start;
    logic [N_VDAC-1:0] i_dac_code;
    logic [N_PRE-1:0]  i_pre_len;
    logic              i_res;
    logic [N_VDAC-1:0] o_dac;
    logic              o_en;
    logic              o_meas;
    logic              o_busy;
    logic              o_done;
    logic [N_CNT-1:0]  o_count;
    logic              o_timeout;

    modport slave (
        input  i_start, i_dac_code, i_pre_len, i_res,
        output o_dac, o_en, o_meas, o_busy, o_done, o_count, o_timeout
    );

    modport master (
        output i_start, i_dac_code, i_pre_len, i_res,
        input  o_dac, o_en, o_meas, o_busy, o_done, o_count, o_timeout
    );
endinterface

// File: rtl/temp_meas_ctrl.sv
// Sequencer for the delay-based temperature sensor: DAC load, precharge,
// delay count until the sensor output rises, then a one-cycle result pulse.
module temp_meas_ctrl #(
    parameter int N_VDAC = 6,
    parameter int N_CNT  = 12,
    parameter int N_PRE  = 4
) (
    input  logic         i_clk,
    input  logic         i_reset,
    temp_meas_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_PRECHARGE = 2'd1,
        S_MEASURE   = 2'd2,
        S_DONE      = 2'd3
    } state_t;

    state_t            state_q,   state_d;
    logic [N_PRE-1:0]  pre_cnt_q, pre_cnt_d;
    logic [N_CNT-1:0]  cnt_q,     cnt_d;
    logic [N_VDAC-1:0] dac_q,     dac_d;
    logic              en_q,      en_d;
    logic              meas_q,    meas_d;
    logic              busy_q,    busy_d;
    logic              done_q,    done_d;
    logic [N_CNT-1:0]  count_q,   count_d;
    logic              timeout_q, timeout_d;

    // i_res is asynchronous to i_clk; res_s_q is the only version the FSM looks at.
    logic res_meta_q;
    logic res_s_q;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            res_meta_q <= 1'b0;
            res_s_q    <= 1'b0;
        end else begin
            res_meta_q <= bus.i_res;
            res_s_q    <= res_meta_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        pre_cnt_d = pre_cnt_q;
        cnt_d     = cnt_q;
        dac_d     = dac_q;
        en_d      = en_q;
        meas_d    = meas_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        count_d   = count_q;
        timeout_d = timeout_q;

        case (state_q)
            S_IDLE: begin
                en_d   = 1'b0;
                meas_d = 1'b0;
                if (bus.i_start) begin
                    dac_d     = bus.i_dac_code;
                    pre_cnt_d = (bus.i_pre_len == '0) ? N_PRE'(1) : bus.i_pre_len;
                    en_d      = 1'b1;
                    busy_d    = 1'b1;
                    state_d   = S_PRECHARGE;
                end
            end

            // Counter holds the remaining cycles, so a load of P gives exactly P cycles here.
            S_PRECHARGE: begin
                if (pre_cnt_q == N_PRE'(1)) begin
                    meas_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = S_MEASURE;
                end else begin
                    pre_cnt_d = pre_cnt_q - N_PRE'(1);
                end
            end

            S_MEASURE: begin
                if (res_s_q) begin
                    count_d   = cnt_q;
                    timeout_d = 1'b0;
                    done_d    = 1'b1;
                    en_d      = 1'b0;
                    meas_d    = 1'b0;
                    state_d   = S_DONE;
                end else if (cnt_q == {N_CNT{1'b1}}) begin
                    count_d   = {N_CNT{1'b1}};
                    timeout_d = 1'b1;
                    done_d    = 1'b1;
                    en_d      = 1'b0;
                    meas_d    = 1'b0;
                    state_d   = S_DONE;
                end else begin
                    cnt_d = cnt_q + N_CNT'(1);
                end
            end

            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q   <= S_IDLE;
            pre_cnt_q <= '0;
            cnt_q     <= '0;
            dac_q     <= '0;
            en_q      <= 1'b0;
            meas_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            count_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pre_cnt_q <= pre_cnt_d;
            cnt_q     <= cnt_d;
            dac_q     <= dac_d;
            en_q      <= en_d;
            meas_q    <= meas_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            count_q   <= count_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.o_dac     = dac_q;
    assign bus.o_en      = en_q;
    assign bus.o_meas    = meas_q;
    assign bus.o_busy    = busy_q;
    assign bus.o_done    = done_q;
    assign bus.o_count   = count_q;
    assign bus.o_timeout = timeout_q;

endmodule

// File: tb/tb_temp_meas_ctrl.sv
// Scenario bench for temp_meas_ctrl: expected results are queued at each start
// and compared when o_done pulses; timing is checked against edge indices.
module tb_temp_meas_ctrl;

    localparam int N_VDAC = 6;
    localparam int N_CNT  = 4;
    localparam int N_PRE  = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    temp_meas_if #(.N_VDAC(N_VDAC), .N_CNT(N_CNT), .N_PRE(N_PRE)) bus ();

    temp_meas_ctrl #(.N_VDAC(N_VDAC), .N_CNT(N_CNT), .N_PRE(N_PRE)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    typedef struct {
        logic [N_CNT-1:0] count;
        logic             timeout;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   txn    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [N_VDAC-1:0] dac, input logic [N_PRE-1:0] pre,
                            output int a);
        bus.i_dac_code = dac;
        bus.i_pre_len  = pre;
        bus.i_start    = 1'b1;
        tick();
        a = cyc;
        bus.i_start = 1'b0;
    endtask

    task automatic wait_meas(input int budget, output int e);
        e = -1;
        for (int i = 0; i < budget; i++) begin
            if (bus.o_meas === 1'b1) begin
                e = cyc;
                break;
            end
            tick();
        end
        checks++;
        if (e < 0) begin
            errors++;
            $display("FAIL wait_meas: o_meas not seen within %0d cycles, required rise", budget);
        end
    endtask

    task automatic wait_done(input int budget, output int d);
        d = -1;
        for (int i = 0; i < budget; i++) begin
            if (bus.o_done === 1'b1) begin
                d = cyc;
                break;
            end
            tick();
        end
        checks++;
        if (d < 0) begin
            errors++;
            $display("FAIL wait_done: o_done not seen within %0d cycles, required pulse", budget);
        end
    endtask

    task automatic pop_exp(output exp_t e, output bit ok);
        ok = (sb.size() != 0);
        if (ok) e = sb.pop_front();
        else begin
            e.count   = '0;
            e.timeout = 1'b0;
        end
        txn++;
        $display("txn %0d: count=%0d timeout=%0b", txn, bus.o_count, bus.o_timeout);
    endtask

    task automatic test_reset();
        rst            = 1'b1;
        bus.i_start    = 1'b1;
        bus.i_dac_code = 6'h3F;
        bus.i_pre_len  = 4'd5;
        bus.i_res      = 1'b0;
        tick();
        tick();
        checks++;
        if ({bus.o_en, bus.o_meas, bus.o_busy, bus.o_done, bus.o_timeout} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: en/meas/busy/done/timeout=%b required 00000",
                     {bus.o_en, bus.o_meas, bus.o_busy, bus.o_done, bus.o_timeout});
        end
        checks++;
        if (bus.o_dac !== '0 || bus.o_count !== '0) begin
            errors++;
            $display("FAIL reset_data: o_dac=%h o_count=%h required 0 0", bus.o_dac, bus.o_count);
        end
        rst         = 1'b0;
        bus.i_start = 1'b0;
        tick();
        checks++;
        if (bus.o_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: o_busy=%b required 0", bus.o_busy);
        end
    endtask

    task automatic test_normal();
        int a, e0, d;
        exp_t ex;
        bit ok;
        sb.push_back('{count: 4'd12, timeout: 1'b0});
        do_start(6'h2A, 4'd4, a);
        bus.i_dac_code = 6'h15;
        bus.i_pre_len  = 4'd1;
        checks++;
        if (bus.o_en !== 1'b1 || bus.o_busy !== 1'b1 || bus.o_meas !== 1'b0) begin
            errors++;
            $display("FAIL normal_start: en/busy/meas=%b%b%b required 110",
                     bus.o_en, bus.o_busy, bus.o_meas);
        end
        checks++;
        if (bus.o_dac !== 6'h2A) begin
            errors++;
            $display("FAIL normal_dac: o_dac=%h required 2a", bus.o_dac);
        end
        wait_meas(30, e0);
        checks++;
        if (e0 != a + 4) begin
            errors++;
            $display("FAIL normal_meas_edge: o_meas rose %0d edges after accept, required 4", e0 - a);
        end
        repeat (10) tick();
        bus.i_res = 1'b1;
        wait_done(40, d);
        checks++;
        if (d != e0 + 13) begin
            errors++;
            $display("FAIL normal_done_edge: done %0d edges after o_meas, required 13", d - e0);
        end
        pop_exp(ex, ok);
        checks++;
        if (!ok || bus.o_count !== ex.count || bus.o_timeout !== ex.timeout) begin
            errors++;
            $display("FAIL normal_result: count=%0d timeout=%b required %0d %b (queued=%0d)",
                     bus.o_count, bus.o_timeout, ex.count, ex.timeout, ok);
        end
        checks++;
        if (bus.o_en !== 1'b0 || bus.o_busy !== 1'b1 || bus.o_dac !== 6'h2A) begin
            errors++;
            $display("FAIL normal_done_state: en=%b busy=%b dac=%h required 0 1 2a",
                     bus.o_en, bus.o_busy, bus.o_dac);
        end
        tick();
        bus.i_res = 1'b0;
        checks++;
        if ({bus.o_done, bus.o_en, bus.o_meas, bus.o_busy} !== 4'b0) begin
            errors++;
            $display("FAIL normal_after: done/en/meas/busy=%b required 0000",
                     {bus.o_done, bus.o_en, bus.o_meas, bus.o_busy});
        end
    endtask

    task automatic test_timeout();
        int a, e0, d;
        exp_t ex;
        bit ok;
        sb.push_back('{count: 4'd15, timeout: 1'b1});
        do_start(6'h05, 4'd2, a);
        wait_meas(30, e0);
        checks++;
        if (e0 != a + 2) begin
            errors++;
            $display("FAIL timeout_meas_edge: o_meas rose %0d edges after accept, required 2", e0 - a);
        end
        wait_done(60, d);
        checks++;
        if (d != e0 + 16) begin
            errors++;
            $display("FAIL timeout_done_edge: done %0d edges after o_meas, required 16", d - e0);
        end
        pop_exp(ex, ok);
        checks++;
        if (!ok || bus.o_count !== ex.count || bus.o_timeout !== ex.timeout) begin
            errors++;
            $display("FAIL timeout_result: count=%0d timeout=%b required %0d %b",
                     bus.o_count, bus.o_timeout, ex.count, ex.timeout);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        int a, e0, n_done;
        do_start(6'h11, 4'd3, a);
        wait_meas(30, e0);
        repeat (3) tick();
        checks++;
        if (bus.o_count !== 4'd15 || bus.o_timeout !== 1'b1 || bus.o_meas !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_pre: count=%0d timeout=%b meas=%b required 15 1 1",
                     bus.o_count, bus.o_timeout, bus.o_meas);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({bus.o_en, bus.o_meas, bus.o_busy, bus.o_done, bus.o_timeout} !== 5'b0 ||
            bus.o_count !== '0 || bus.o_dac !== '0) begin
            errors++;
            $display("FAIL rstmid_clear: en/meas/busy/done/timeout=%b count=%0d dac=%h required all 0",
                     {bus.o_en, bus.o_meas, bus.o_busy, bus.o_done, bus.o_timeout},
                     bus.o_count, bus.o_dac);
        end
        n_done = 0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (bus.o_done === 1'b1) n_done++;
        end
        checks++;
        if (n_done != 0) begin
            errors++;
            $display("FAIL rstmid_no_done: %0d done pulses, required 0", n_done);
        end
    endtask

    task automatic test_ignored_start();
        int a, e0, d, n_done, n_busy;
        exp_t ex;
        bit ok;
        sb.push_back('{count: 4'd5, timeout: 1'b0});
        do_start(6'h08, 4'd1, a);
        wait_meas(30, e0);
        tick();
        bus.i_start = 1'b1;
        tick();
        bus.i_start = 1'b0;
        tick();
        bus.i_res = 1'b1;
        wait_done(40, d);
        checks++;
        if (d != e0 + 6) begin
            errors++;
            $display("FAIL ignored_done_edge: done %0d edges after o_meas, required 6", d - e0);
        end
        pop_exp(ex, ok);
        checks++;
        if (!ok || bus.o_count !== ex.count || bus.o_timeout !== ex.timeout) begin
            errors++;
            $display("FAIL ignored_result: count=%0d timeout=%b required %0d %b",
                     bus.o_count, bus.o_timeout, ex.count, ex.timeout);
        end
        bus.i_start = 1'b1;
        tick();
        bus.i_start = 1'b0;
        bus.i_res   = 1'b0;
        n_done = 0;
        n_busy = 0;
        for (int i = 0; i < 30; i++) begin
            if (bus.o_done === 1'b1) n_done++;
            if (bus.o_busy !== 1'b0) n_busy++;
            tick();
        end
        checks++;
        if (n_done != 0 || n_busy != 0) begin
            errors++;
            $display("FAIL ignored_extra: %0d extra done, %0d busy cycles, required 0 0",
                     n_done, n_busy);
        end
    endtask

    task automatic test_back_to_back();
        int a, e0, d, a2;
        exp_t ex;
        bit ok;
        sb.push_back('{count: 4'd3, timeout: 1'b0});
        do_start(6'h30, 4'd2, a);
        wait_meas(30, e0);
        tick();
        bus.i_res = 1'b1;
        wait_done(40, d);
        checks++;
        if (d != e0 + 4) begin
            errors++;
            $display("FAIL b2b_done1_edge: done %0d edges after o_meas, required 4", d - e0);
        end
        pop_exp(ex, ok);
        checks++;
        if (!ok || bus.o_count !== ex.count || bus.o_timeout !== ex.timeout) begin
            errors++;
            $display("FAIL b2b_result1: count=%0d timeout=%b required %0d %b",
                     bus.o_count, bus.o_timeout, ex.count, ex.timeout);
        end
        bus.i_res = 1'b0;
        sb.push_back('{count: 4'd4, timeout: 1'b0});
        bus.i_dac_code = 6'h07;
        bus.i_pre_len  = 4'd3;
        bus.i_start    = 1'b1;
        tick();
        checks++;
        if (bus.o_busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_done_ignores: o_busy=%b required 0", bus.o_busy);
        end
        tick();
        a2 = cyc;
        bus.i_start = 1'b0;
        checks++;
        if (bus.o_busy !== 1'b1 || bus.o_dac !== 6'h07) begin
            errors++;
            $display("FAIL b2b_accept: busy=%b dac=%h required 1 07", bus.o_busy, bus.o_dac);
        end
        wait_meas(30, e0);
        checks++;
        if (e0 != a2 + 3) begin
            errors++;
            $display("FAIL b2b_meas_edge: o_meas rose %0d edges after accept, required 3", e0 - a2);
        end
        repeat (2) tick();
        bus.i_res = 1'b1;
        wait_done(40, d);
        checks++;
        if (d != e0 + 5) begin
            errors++;
            $display("FAIL b2b_done2_edge: done %0d edges after o_meas, required 5", d - e0);
        end
        pop_exp(ex, ok);
        checks++;
        if (!ok || bus.o_count !== ex.count || bus.o_timeout !== ex.timeout) begin
            errors++;
            $display("FAIL b2b_result2: count=%0d timeout=%b required %0d %b",
                     bus.o_count, bus.o_timeout, ex.count, ex.timeout);
        end
        bus.i_res = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_p0_early();
        int a, e0, d;
        exp_t ex;
        bit ok;
        bus.i_res = 1'b1;
        repeat (3) tick();
        sb.push_back('{count: 4'd0, timeout: 1'b0});
        do_start(6'h3C, 4'd0, a);
        wait_meas(30, e0);
        checks++;
        if (e0 != a + 1) begin
            errors++;
            $display("FAIL p0_meas_edge: o_meas rose %0d edges after accept, required 1", e0 - a);
        end
        wait_done(40, d);
        checks++;
        if (d != e0 + 1) begin
            errors++;
            $display("FAIL p0_done_edge: done %0d edges after o_meas, required 1", d - e0);
        end
        pop_exp(ex, ok);
        checks++;
        if (!ok || bus.o_count !== ex.count || bus.o_timeout !== ex.timeout) begin
            errors++;
            $display("FAIL p0_result: count=%0d timeout=%b required %0d %b",
                     bus.o_count, bus.o_timeout, ex.count, ex.timeout);
        end
        bus.i_res = 1'b0;
        repeat (3) tick();
    endtask

    initial begin
        rst            = 1'b1;
        bus.i_start    = 1'b0;
        bus.i_dac_code = '0;
        bus.i_pre_len  = '0;
        bus.i_res      = 1'b0;
        test_reset();
        test_normal();
        test_timeout();
        test_reset_mid();
        test_ignored_start();
        test_back_to_back();
        test_p0_early();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d results outstanding, required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
